// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing IF/ID/EX/MEM/WB for the 16-bit multi-cycle RISC datapath
module multicycle_control_unit #(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               enable_IF,
    output logic               enable_ID,
    output logic               enable_EX,
    output logic               enable_MEM,
    output logic [1:0]         RAsrc,
    output logic               RBsrc,
    output logic               regDst,
    output logic               ExtOp,
    output logic               ALUsrc,
    output logic [1:0]         ALUop,
    output logic               memRd,
    output logic               memWr,
    output logic               regWr,
    output logic [1:0]         wbSel,
    output logic               pcWr,
    output logic [1:0]         pcSrc,
    output logic [STATE_W-1:0] state_o
);
    localparam logic [STATE_W-1:0] S_IF  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_ID  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_EX  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEM = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_WB  = STATE_W'(4);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_ANDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_CALL = 4'd10;
    localparam logic [3:0] OP_RET  = 4'd11;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_st;
    logic [3:0]         r_op;

    // while reset is held the outputs show the IF state so an aborted access never strobes
    assign w_st    = reset ? S_IF : r_state;
    assign state_o = w_st;

    // state register and opcode latch captured during decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IF;
            r_op    <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID)
                r_op <= opcode;
        end
    end

    // next-state selection; ID uses the live opcode, later stages use the latched one
    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF:  w_next = S_ID;
            S_ID:  w_next = (opcode == OP_JMP || opcode == OP_RET || opcode >= 4'd12) ? S_IF :
                            (opcode == OP_CALL) ? S_WB : S_EX;
            S_EX:  w_next = (r_op == OP_BEQ || r_op == OP_BNE) ? S_IF :
                            (r_op == OP_LW || r_op == OP_SW) ? S_MEM : S_WB;
            S_MEM: w_next = !mem_ready ? S_MEM : (r_op == OP_LW) ? S_WB : S_IF;
            S_WB:  w_next = S_IF;
            default: w_next = S_IF;
        endcase
    end

    // Moore outputs per state; illegal state codes drive everything low
    always_comb begin
        enable_IF  = 1'b0;
        enable_ID  = 1'b0;
        enable_EX  = 1'b0;
        enable_MEM = 1'b0;
        RAsrc      = 2'b00;
        RBsrc      = 1'b0;
        regDst     = 1'b0;
        ExtOp      = 1'b0;
        ALUsrc     = 1'b0;
        ALUop      = 2'b00;
        memRd      = 1'b0;
        memWr      = 1'b0;
        regWr      = 1'b0;
        wbSel      = 2'b00;
        pcWr       = 1'b0;
        pcSrc      = 2'b00;
        case (w_st)
            S_IF: enable_IF = 1'b1;
            S_ID: begin
                enable_ID = 1'b1;
                RAsrc     = (opcode == OP_RET) ? 2'b01 : 2'b00;
                RBsrc     = opcode == OP_SW || opcode == OP_BEQ || opcode == OP_BNE;
                ExtOp     = opcode != OP_ANDI;
                pcWr      = opcode == OP_JMP || opcode == OP_RET;
                pcSrc     = (opcode == OP_JMP) ? 2'b10 : (opcode == OP_RET) ? 2'b11 : 2'b00;
            end
            S_EX: begin
                enable_EX = 1'b1;
                ALUsrc    = r_op == OP_ADDI || r_op == OP_ANDI || r_op == OP_LW || r_op == OP_SW;
                ALUop     = (r_op == OP_AND || r_op == OP_ANDI) ? 2'b00 :
                            (r_op == OP_SUB || r_op == OP_BEQ || r_op == OP_BNE) ? 2'b10 : 2'b01;
                pcWr      = (r_op == OP_BEQ) ? zero : (r_op == OP_BNE) ? ~zero : 1'b0;
                pcSrc     = (r_op == OP_BEQ || r_op == OP_BNE) ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                enable_MEM = 1'b1;
                memRd      = r_op == OP_LW;
                memWr      = r_op == OP_SW;
            end
            S_WB: begin
                regWr  = 1'b1;
                wbSel  = (r_op == OP_LW) ? 2'b01 : (r_op == OP_CALL) ? 2'b10 : 2'b00;
                regDst = r_op == OP_CALL;
                pcWr   = r_op == OP_CALL;
                pcSrc  = (r_op == OP_CALL) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed instruction sequences with a queued per-cycle output scoreboard
module tb_multicycle_control_unit;
    typedef struct packed {
        logic [2:0] st;
        logic       eif, eid, eex, emem;
        logic [1:0] ra;
        logic       rb, rd, ext, asrc;
        logic [1:0] aop;
        logic       mrd, mwr, rwr;
        logic [1:0] wb;
        logic       pcw;
        logic [1:0] pcs;
    } ov_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       enable_IF, enable_ID, enable_EX, enable_MEM;
    logic [1:0] RAsrc, ALUop, wbSel, pcSrc;
    logic       RBsrc, regDst, ExtOp, ALUsrc, memRd, memWr, regWr, pcWr;
    logic [2:0] state_o;
    ov_t        act;

    ov_t q_exp[$];
    int  q_tag[$];
    int  checks = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.STATE_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .enable_IF(enable_IF), .enable_ID(enable_ID), .enable_EX(enable_EX), .enable_MEM(enable_MEM),
        .RAsrc(RAsrc), .RBsrc(RBsrc), .regDst(regDst), .ExtOp(ExtOp), .ALUsrc(ALUsrc),
        .ALUop(ALUop), .memRd(memRd), .memWr(memWr), .regWr(regWr), .wbSel(wbSel),
        .pcWr(pcWr), .pcSrc(pcSrc), .state_o(state_o)
    );

    assign act = {state_o, enable_IF, enable_ID, enable_EX, enable_MEM, RAsrc, RBsrc, regDst,
                  ExtOp, ALUsrc, ALUop, memRd, memWr, regWr, wbSel, pcWr, pcSrc};

    function automatic ov_t e_if();
        ov_t e = '0;
        e.eif = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_id(input logic [1:0] ra, input logic rb, input logic ext,
                                 input logic pcw, input logic [1:0] pcs);
        ov_t e = '0;
        e.st = 3'd1; e.eid = 1'b1; e.ra = ra; e.rb = rb; e.ext = ext; e.pcw = pcw; e.pcs = pcs;
        return e;
    endfunction

    function automatic ov_t e_ex(input logic asrc, input logic [1:0] aop,
                                 input logic pcw, input logic [1:0] pcs);
        ov_t e = '0;
        e.st = 3'd2; e.eex = 1'b1; e.asrc = asrc; e.aop = aop; e.pcw = pcw; e.pcs = pcs;
        return e;
    endfunction

    function automatic ov_t e_mem(input logic mrd, input logic mwr);
        ov_t e = '0;
        e.st = 3'd3; e.emem = 1'b1; e.mrd = mrd; e.mwr = mwr;
        return e;
    endfunction

    function automatic ov_t e_wb(input logic [1:0] wb, input logic rd,
                                 input logic pcw, input logic [1:0] pcs);
        ov_t e = '0;
        e.st = 3'd4; e.rwr = 1'b1; e.wb = wb; e.rd = rd; e.pcw = pcw; e.pcs = pcs;
        return e;
    endfunction

    task automatic step(input logic rst, input logic [3:0] op, input logic z, input logic mr,
                        input ov_t e, input int tag);
        @(posedge clk);
        #1;
        reset = rst;
        opcode = op;
        zero = z;
        mem_ready = mr;
        q_exp.push_back(e);
        q_tag.push_back(tag);
    endtask

    // monitor: compares every presented cycle against the oldest queued expectation
    initial begin
        ov_t e;
        int  t;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                t = q_tag.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL test%0d t=%0t got=%h expected=%h (st got %0d exp %0d)",
                             t, $time, act, e, act.st, e.st);
                end
            end
        end
    end

    initial begin
        // reset state
        step(1, 4'd0, 0, 1, e_if(), 1);
        step(1, 4'd0, 0, 1, e_if(), 1);
        // ADD: 0,1,2,4
        step(0, 4'd1, 0, 1, e_if(), 2);
        step(0, 4'd1, 0, 1, e_id(2'b00, 0, 1, 0, 2'b00), 2);
        step(0, 4'd1, 0, 1, e_ex(0, 2'b01, 0, 2'b00), 2);
        step(0, 4'd1, 0, 1, e_wb(2'b00, 0, 0, 2'b00), 2);
        // LW with three wait cycles
        step(0, 4'd5, 0, 0, e_if(), 3);
        step(0, 4'd5, 0, 0, e_id(2'b00, 0, 1, 0, 2'b00), 3);
        step(0, 4'd5, 0, 0, e_ex(1, 2'b01, 0, 2'b00), 3);
        for (int i = 0; i < 3; i++) step(0, 4'd5, 0, 0, e_mem(1, 0), 3);
        step(0, 4'd5, 0, 1, e_mem(1, 0), 3);
        step(0, 4'd5, 0, 1, e_wb(2'b01, 0, 0, 2'b00), 3);
        // BEQ taken
        step(0, 4'd7, 1, 1, e_if(), 4);
        step(0, 4'd7, 1, 1, e_id(2'b00, 1, 1, 0, 2'b00), 4);
        step(0, 4'd7, 1, 1, e_ex(0, 2'b10, 1, 2'b01), 4);
        // BNE not taken
        step(0, 4'd8, 1, 1, e_if(), 5);
        step(0, 4'd8, 1, 1, e_id(2'b00, 1, 1, 0, 2'b00), 5);
        step(0, 4'd8, 1, 1, e_ex(0, 2'b10, 0, 2'b01), 5);
        // CALL
        step(0, 4'd10, 0, 1, e_if(), 6);
        step(0, 4'd10, 0, 1, e_id(2'b00, 0, 1, 0, 2'b00), 6);
        step(0, 4'd10, 0, 1, e_wb(2'b10, 1, 1, 2'b10), 6);
        // RET
        step(0, 4'd11, 0, 1, e_if(), 7);
        step(0, 4'd11, 0, 1, e_id(2'b01, 0, 1, 1, 2'b11), 7);
        // illegal opcode 14
        step(0, 4'd14, 0, 1, e_if(), 8);
        step(0, 4'd14, 0, 1, e_id(2'b00, 0, 1, 0, 2'b00), 8);
        // JMP
        step(0, 4'd9, 0, 1, e_if(), 9);
        step(0, 4'd9, 0, 1, e_id(2'b00, 0, 1, 1, 2'b10), 9);
        // ANDI
        step(0, 4'd4, 0, 1, e_if(), 10);
        step(0, 4'd4, 0, 1, e_id(2'b00, 0, 0, 0, 2'b00), 10);
        step(0, 4'd4, 0, 1, e_ex(1, 2'b00, 0, 2'b00), 10);
        step(0, 4'd4, 0, 1, e_wb(2'b00, 0, 0, 2'b00), 10);
        // SUB
        step(0, 4'd2, 0, 1, e_if(), 11);
        step(0, 4'd2, 0, 1, e_id(2'b00, 0, 1, 0, 2'b00), 11);
        step(0, 4'd2, 0, 1, e_ex(0, 2'b10, 0, 2'b00), 11);
        step(0, 4'd2, 0, 1, e_wb(2'b00, 0, 0, 2'b00), 11);
        // SW, memory already ready
        step(0, 4'd6, 0, 1, e_if(), 12);
        step(0, 4'd6, 0, 1, e_id(2'b00, 1, 1, 0, 2'b00), 12);
        step(0, 4'd6, 0, 1, e_ex(1, 2'b01, 0, 2'b00), 12);
        step(0, 4'd6, 0, 1, e_mem(0, 1), 12);
        // SW aborted by reset held three cycles in MEM
        step(0, 4'd6, 0, 0, e_if(), 13);
        step(0, 4'd6, 0, 0, e_id(2'b00, 1, 1, 0, 2'b00), 13);
        step(0, 4'd6, 0, 0, e_ex(1, 2'b01, 0, 2'b00), 13);
        step(0, 4'd6, 0, 0, e_mem(0, 1), 13);
        for (int i = 0; i < 3; i++) step(1, 4'd6, 0, 0, e_if(), 13);
        step(0, 4'd1, 0, 1, e_if(), 13);
        step(0, 4'd1, 0, 1, e_id(2'b00, 0, 1, 0, 2'b00), 13);
        step(0, 4'd1, 0, 1, e_ex(0, 2'b01, 0, 2'b00), 13);
        step(0, 4'd1, 0, 1, e_wb(2'b00, 0, 0, 2'b00), 13);
        step(0, 4'd1, 0, 1, e_if(), 13);
        for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(negedge clk);
        #1;
        if (q_exp.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM that sequences the multi-cycle 16-bit RISC datapath through IF, ID, EX, MEM and WB.
- Issues the stage enables, the register-file and extender selects consumed by the decode stage, and the ALU, memory, write-back and PC-update controls.
- Sits beside the datapath. It takes opcode from the decode stage and zero from the ALU, and waits on data-memory ready for loads and stores.

Parameters:
- STATE_W, 3, width of the state encoding and of state_o.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- opcode  input  4  instruction[15:12] from decode; valid from ID onward
- zero  input  1  ALU zero flag; valid in EX
- mem_ready  input  1  data-memory ready/done for the current access
- enable_IF  output  1  PC/IR write enable (fetch)
- enable_ID  output  1  decode-stage enable
- enable_EX  output  1  ALU-stage enable
- enable_MEM  output  1  memory-stage enable
- RAsrc  output  2  00=rs1, 01=R7, 10=R0
- RBsrc  output  1  0=rs2, 1=rd
- regDst  output  1  0=rd, 1=R7
- ExtOp  output  1  1=sign-extend, 0=zero-extend imm5
- ALUsrc  output  1  0=BusB, 1=Imm16
- ALUop  output  2  00=AND, 01=ADD, 10=SUB
- memRd  output  1  data-memory read strobe
- memWr  output  1  data-memory write strobe
- regWr  output  1  register-file write
- wbSel  output  2  00=ALU, 01=memory data, 10=nextPC
- pcWr  output  1  PC load outside IF
- pcSrc  output  2  00=PC+2, 01=BTarget, 10=jumpTarget, 11=BusA
- state_o  output  STATE_W  current state, for debug

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5–7 are illegal and go to IF on the next edge.
- Opcode map:
  - 0 AND, 1 ADD, 2 SUB: R-type.
  - 3 ADDI, 4 ANDI: I-type.
  - 5 LW, 6 SW.
  - 7 BEQ, 8 BNE: compare rd against rs1.
  - 9 JMP, 10 CALL, 11 RET.
  - 12–15 are illegal and execute as a NOP.
- Reset:
  - state=IF.
  - All outputs 0 except the IF-state values: enable_IF=1, pcSrc=00.
  - Reset mid-instruction aborts the instruction; no regWr, memWr or pcWr is issued on that edge.
- IF: enable_IF=1, pcSrc=00. Next state is ID.
- ID:
  - Drives enable_ID=1 and the RAsrc/RBsrc/ExtOp selects, decoded from the live opcode.
  - Latches opcode into op_q; EX, MEM and WB decode from op_q.
  - RAsrc: 01 for RET, 00 otherwise.
  - RBsrc: 1 for SW, BEQ and BNE; 0 otherwise.
  - ExtOp: 0 for ANDI, 1 otherwise.
  - JMP: pcWr=1, pcSrc=10, next state IF.
  - RET: pcWr=1, pcSrc=11, next state IF.
  - CALL: next state WB.
  - Illegal opcode: next state IF.
  - All other opcodes: next state EX.
- EX:
  - enable_EX=1.
  - ALUsrc=1 for ADDI, ANDI, LW and SW.
  - ALUop: AND/ANDI give 00; ADD/ADDI/LW/SW give 01; BEQ/BNE give 10.
  - BEQ: pcWr=zero, pcSrc=01.
  - BNE: pcWr=~zero, pcSrc=01.
  - Branches then go to IF. LW and SW go to MEM; all others go to WB.
- MEM:
  - enable_MEM=1.
  - memRd=1 for LW; memWr=1 for SW.
  - The strobe is held while mem_ready=0, and the FSM stays in MEM.
  - On mem_ready=1: LW goes to WB, SW goes to IF.
  - mem_ready already high on MEM entry gives a single MEM cycle.
- WB:
  - regWr=1 for exactly one cycle. Next state is IF.
  - wbSel: 01 for LW, 10 for CALL, 00 otherwise.
  - regDst: 1 for CALL, 0 otherwise.
  - CALL also asserts pcWr=1, pcSrc=10 in the same cycle.
- Cycle counts with mem_ready=1:
  - R-type, I-type: 4.
  - LW: 5. SW: 4.
  - BEQ/BNE: 3.
  - JMP, RET: 2. CALL: 3. Illegal: 2.
- regWr, memWr and pcWr must never be asserted in IF, and at most one of memRd/memWr is asserted at any time.
- Outputs are combinational from (state, op_q) and, in ID only, from opcode. They must be glitch-free relative to the clock edge; registered equivalents are not allowed, since they would add latency.

Test Plan:
- reset held 3 cycles during MEM of an SW → state_o=0, memWr=0, enable_IF=1 on the cycle after reset drops. The SW write never completes.
- ADD (opcode 1) → state_o sequence 0,1,2,4,0; ALUop=01 and ALUsrc=0 in EX; regWr=1 only in WB with wbSel=00, regDst=0.
- LW with mem_ready low for 3 MEM cycles → memRd=1 for 4 consecutive cycles, then WB with wbSel=01, regWr=1. Total 8 cycles.
- BEQ with zero=1 → pcWr=1, pcSrc=01 in EX, 3-cycle instruction. BNE with zero=1 → pcWr=0 in EX.
- CALL (10) → ID→WB with regDst=1, wbSel=10, regWr=1, pcWr=1, pcSrc=10. RET (11) → RAsrc=01, pcSrc=11, pcWr=1 in ID, 2 cycles.
- opcode 14 → IF,ID,IF with no regWr/memWr/pcWr. ANDI → ExtOp=0 in ID; SW → RBsrc=1 in ID.
